calc_sequencer: RTL and testbench
=================================

# calc_sequencer

Top-level control FSM of the four-digit keypad calculator. It receives decoded keypad events and sequences the whole operation: operand 1 entry, operator selection, operand 2 entry, the ALU computation handshake and result display. It drives the digit-load enables of the operand entry registers, the ALU start and operator select, and the display source mux. The block holds no operand data; it only counts digits and steers the existing datapath.

## Interface
- DIGITS, 4, maximum digits accepted per operand.
- TIMEOUT_CYCLES, 1024, ALU watchdog limit in cycles; used only with CALC_TIMEOUT_EN.
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  level from keypad decoder, high while a key is held.
- key_code  in  4  0x0–0x9 digit, 0xA add, 0xB subtract, 0xE equals, 0xF clear, 0xC/0xD ignored.
- alu_done  in  1  ALU result valid; one-cycle pulse or level.
- num1_en  out  1  one-cycle pulse: shift `digit` into operand 1.
- num2_en  out  1  one-cycle pulse: shift `digit` into operand 2.
- digit  out  4  registered digit value; valid while num1_en or num2_en is high.
- clr  out  1  one-cycle pulse: clear both operand registers.
- res_to_op1  out  1  one-cycle pulse: copy the ALU result into operand 1.
- op_sel  out  1  0 = add, 1 = subtract; held until the next operator key.
- alu_start  out  1  one-cycle pulse requesting a computation.
- disp_sel  out  2  00 operand 1, 01 operand 2, 10 result, 11 error.
- digit_count  out  $clog2(DIGITS+1)  digits entered into the current operand.
- busy  out  1  high in CALC.

## Operation
- Key event = rising edge of key_valid (key_valid high, previous sample low). key_code is captured in the same cycle. A held key produces exactly one event.
- States: N1, N2, CALC, SHOW, ERR. Reset state is N1.
- **N1**, disp_sel=00:
  - Digit: if digit_count<DIGITS, pulse num1_en and increment the count. Otherwise ignore the key.
  - Operator: latch op_sel, clear the count, go to N2. Zero digits entered counts as operand 0.
  - Equals: ignored.
- **N2**, disp_sel=01:
  - Digit: if digit_count<DIGITS, pulse num2_en and increment the count. Otherwise ignore the key.
  - Operator: re-latch op_sel only.
  - Equals: if count≥1, pulse alu_start and go to CALC. If count is 0, ignore the key.
- **CALC**, busy=1, disp_sel unchanged (01):
  - All keys except clear are ignored.
  - alu_done → go to SHOW.
- **SHOW**, disp_sel=10:
  - Digit: pulse clr, then num1_en on the next cycle; count=1; go to N1.
  - Operator: pulse res_to_op1, latch op_sel, count=0; go to N2.
  - Equals: pulse alu_start again with the same operands; go to CALC.
- **ERR**, disp_sel=11: only clear is accepted.
- Clear (0xF) in any state: pulse clr, count=0, op_sel=0, go to N1.
- Priority:
  - Clear beats alu_done in the same cycle.
  - alu_done outside CALC is ignored.
  - Codes 0xC and 0xD never change state.
- Reset values:
  - All pulse outputs 0.
  - op_sel=0, disp_sel=00, digit=0, digit_count=0, busy=0.
  - Watchdog counter 0, edge-detect history 0.
- Reset asserted mid-operation aborts it. Any pending pulse is suppressed.

## Timing
- Registered outputs. A pulse appears exactly one cycle after the cycle the key edge is sampled.
- Exception: SHOW+digit gives clr at edge+1 and num1_en at edge+2.
- alu_start is high for exactly one cycle, when CALC is entered.
- alu_done sampled high in CALC: disp_sel=10 and busy=0 on the next cycle.
- Minimum spacing between accepted keys: 2 cycles. Back-to-back edges are each processed.

## Configuration
- CALC_TIMEOUT_EN defined:
  - A counter runs while in CALC.
  - Reaching TIMEOUT_CYCLES without alu_done → ERR, busy=0, disp_sel=11.
  - The counter clears on leaving CALC.
- Undefined: the counter is not built; CALC waits indefinitely for alu_done and ERR is unreachable.

## Structure
- Shared package calc_pkg holds:
  - key code constants (KEY_ADD, KEY_SUB, KEY_EQ, KEY_CLR);
  - state encoding;
  - disp_sel encodings.
- Sub-module key_edge_detect: previous-sample register, rising-edge pulse, key_code capture. The FSM, digit counter and watchdog stay in calc_sequencer.

## Test plan
- Reset, then keys 1,2,+,3,=, then alu_done after 5 cycles:
  - num1_en pulses with digit 1 then 2;
  - op_sel=0;
  - num2_en with digit 3;
  - one alu_start;
  - disp_sel=10 one cycle after alu_done.
- Keys 1,2,3,4,5 in N1 → four num1_en pulses, digit_count=4, fifth key produces no pulse.
- Key_valid held high for 20 cycles with code 7 → exactly one num1_en.
- In SHOW: key −, then 9, then = → res_to_op1, op_sel=1, num2_en with digit 9, alu_start.
- In CALC: clear and alu_done in the same cycle → clr pulse, state N1, disp_sel=00, no transition to SHOW.
- With CALC_TIMEOUT_EN and TIMEOUT_CYCLES=16, no alu_done → disp_sel=11 after 16 cycles; digit keys ignored; clear returns to N1.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared constants for the keypad calculator: key codes, sequencer state
// encoding and display-source selects.
package calc_pkg;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  typedef logic [2:0] state_t;

  localparam state_t ST_N1   = 3'd0;
  localparam state_t ST_N2   = 3'd1;
  localparam state_t ST_CALC = 3'd2;
  localparam state_t ST_SHOW = 3'd3;
  localparam state_t ST_ERR  = 3'd4;

  localparam logic [1:0] DISP_OP1 = 2'b00;
  localparam logic [1:0] DISP_OP2 = 2'b01;
  localparam logic [1:0] DISP_RES = 2'b10;
  localparam logic [1:0] DISP_ERR = 2'b11;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'h9;
  endfunction

  function automatic logic is_operator(input logic [3:0] code);
    return (code == KEY_ADD) || (code == KEY_SUB);
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Turns the keypad's held key_valid level into a single-cycle event and
// presents the key code that belongs to that event.
module key_edge_detect (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_key_valid,
  input  logic [3:0] i_key_code,
  output logic       o_key_evt,
  output logic [3:0] o_key_code
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_prev <= 1'b0;
    else         r_prev <= i_key_valid;
  end

  // Event and code are combinational so the FSM acts on the same edge.
  assign o_key_evt  = i_key_valid & ~r_prev;
  assign o_key_code = i_key_code;

endmodule

// File: rtl/calc_sequencer.sv
// Top-level keypad calculator sequencer: operand entry, operator, ALU handshake, display.
// Optional ALU watchdog is built when CALC_TIMEOUT_EN is defined.
//
// state | meaning
// N1    | entering operand 1, display operand 1
// N2    | entering operand 2, display operand 2
// CALC  | waiting for alu_done, busy high
// SHOW  | displaying the result
// ERR   | ALU watchdog expired, only clear accepted
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         key_valid,
  input  logic [3:0]                   key_code,
  input  logic                         alu_done,
  output logic                         num1_en,
  output logic                         num2_en,
  output logic [3:0]                   digit,
  output logic                         clr,
  output logic                         res_to_op1,
  output logic                         op_sel,
  output logic                         alu_start,
  output logic [1:0]                   disp_sel,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         busy
);

  localparam int CNT_W = $clog2(DIGITS + 1);

  logic             w_key_evt;
  logic [3:0]       w_code;
  logic             w_clr_evt;
  logic             w_digit_ok;
  logic             w_timeout;

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [3:0]       r_digit;
  logic             r_op_sel;
  logic             r_num1_en;
  logic             r_num2_en;
  logic             r_clr;
  logic             r_res_to_op1;
  logic             r_alu_start;
  logic             r_pend_num1;

  key_edge_detect u_key_edge (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_key_valid (key_valid),
    .i_key_code  (key_code),
    .o_key_evt   (w_key_evt),
    .o_key_code  (w_code)
  );

  assign w_clr_evt  = w_key_evt && (w_code == KEY_CLR);
  assign w_digit_ok = w_key_evt && is_digit(w_code) && (r_count < CNT_W'(DIGITS));

`ifdef CALC_TIMEOUT_EN
  localparam int WDOG_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDOG_W-1:0] r_wdog;

  assign w_timeout = (r_state == ST_CALC) && (r_wdog == WDOG_W'(TIMEOUT_CYCLES - 1));

  // Counts only while staying in CALC; any exit from CALC returns it to 0.
  always_ff @(posedge clk) begin
    if (reset)
      r_wdog <= '0;
    else if ((r_state == ST_CALC) && !alu_done && !w_clr_evt && !w_timeout)
      r_wdog <= r_wdog + 1'b1;
    else
      r_wdog <= '0;
  end
`else
  // Watchdog not built: CALC waits for alu_done indefinitely.
  assign w_timeout = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_N1;
      r_count      <= '0;
      r_digit      <= 4'h0;
      r_op_sel     <= 1'b0;
      r_num1_en    <= 1'b0;
      r_num2_en    <= 1'b0;
      r_clr        <= 1'b0;
      r_res_to_op1 <= 1'b0;
      r_alu_start  <= 1'b0;
      r_pend_num1  <= 1'b0;
    end else begin
      r_num1_en    <= r_pend_num1;
      r_pend_num1  <= 1'b0;
      r_num2_en    <= 1'b0;
      r_clr        <= 1'b0;
      r_res_to_op1 <= 1'b0;
      r_alu_start  <= 1'b0;

      if (w_clr_evt) begin
        r_clr     <= 1'b1;
        r_num1_en <= 1'b0;
        r_count   <= '0;
        r_op_sel  <= 1'b0;
        r_state   <= ST_N1;
      end else begin
        case (r_state)
          ST_N1: begin
            if (w_digit_ok) begin
              r_num1_en <= 1'b1;
              r_digit   <= w_code;
              r_count   <= r_count + 1'b1;
            end else if (w_key_evt && is_operator(w_code)) begin
              r_op_sel <= (w_code == KEY_SUB);
              r_count  <= '0;
              r_state  <= ST_N2;
            end
          end
          ST_N2: begin
            if (w_digit_ok) begin
              r_num2_en <= 1'b1;
              r_digit   <= w_code;
              r_count   <= r_count + 1'b1;
            end else if (w_key_evt && is_operator(w_code)) begin
              r_op_sel <= (w_code == KEY_SUB);
            end else if (w_key_evt && (w_code == KEY_EQ) && (r_count != '0)) begin
              r_alu_start <= 1'b1;
              r_state     <= ST_CALC;
            end
          end
          ST_CALC: begin
            if (alu_done)       r_state <= ST_SHOW;
            else if (w_timeout) r_state <= ST_ERR;
          end
          ST_SHOW: begin
            // A new digit starts a fresh operand 1: clear first, load a cycle later.
            if (w_key_evt && is_digit(w_code)) begin
              r_clr       <= 1'b1;
              r_pend_num1 <= 1'b1;
              r_digit     <= w_code;
              r_count     <= CNT_W'(1);
              r_state     <= ST_N1;
            end else if (w_key_evt && is_operator(w_code)) begin
              r_res_to_op1 <= 1'b1;
              r_op_sel     <= (w_code == KEY_SUB);
              r_count      <= '0;
              r_state      <= ST_N2;
            end else if (w_key_evt && (w_code == KEY_EQ)) begin
              r_alu_start <= 1'b1;
              r_state     <= ST_CALC;
            end
          end
          ST_ERR:  r_state <= ST_ERR;
          default: r_state <= ST_N1;
        endcase
      end
    end
  end

  always_comb begin
    disp_sel = DISP_OP1;
    case (r_state)
      ST_N2, ST_CALC: disp_sel = DISP_OP2;
      ST_SHOW:        disp_sel = DISP_RES;
      ST_ERR:         disp_sel = DISP_ERR;
      default:        disp_sel = DISP_OP1;
    endcase
  end

  assign busy        = (r_state == ST_CALC);
  assign num1_en     = r_num1_en;
  assign num2_en     = r_num2_en;
  assign digit       = r_digit;
  assign clr         = r_clr;
  assign res_to_op1  = r_res_to_op1;
  assign op_sel      = r_op_sel;
  assign alu_start   = r_alu_start;
  assign digit_count = r_count;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed self-checking bench for calc_sequencer; the watchdog scenario
// runs with TIMEOUT_CYCLES=16 when CALC_TIMEOUT_EN is defined.
module tb_calc_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic       alu_done;
  logic       num1_en, num2_en, clr, res_to_op1, op_sel, alu_start, busy;
  logic [3:0] digit;
  logic [1:0] disp_sel;
  logic [2:0] digit_count;

  int total = 0;
  int bad   = 0;

  int n_num1 = 0, n_num2 = 0, n_start = 0, n_clr = 0;

  logic       s_num1, s_num2, s_clr, s_res, s_start, s_op, s2_num1, s2_clr;
  logic [3:0] s_digit;
  logic [1:0] s_disp;
  logic [2:0] s_count;

  calc_sequencer #(.DIGITS(4), .TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .alu_done    (alu_done),
    .num1_en     (num1_en),
    .num2_en     (num2_en),
    .digit       (digit),
    .clr         (clr),
    .res_to_op1  (res_to_op1),
    .op_sel      (op_sel),
    .alu_start   (alu_start),
    .disp_sel    (disp_sel),
    .digit_count (digit_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (num1_en)   n_num1++;
    if (num2_en)   n_num2++;
    if (alu_start) n_start++;
    if (clr)       n_clr++;
  end

  task automatic clear_counts();
    n_num1 = 0; n_num2 = 0; n_start = 0; n_clr = 0;
  endtask

  // One key press: edge sampled at posedge P, outputs captured after P and P+1.
  task automatic press(input logic [3:0] c);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = c;
    @(posedge clk); #1;
    s_num1 = num1_en; s_num2 = num2_en; s_clr = clr; s_res = res_to_op1;
    s_start = alu_start; s_op = op_sel; s_digit = digit; s_disp = disp_sel;
    s_count = digit_count;
    @(negedge clk);
    key_valid = 1'b0;
    @(posedge clk); #1;
    s2_num1 = num1_en; s2_clr = clr;
  endtask

  task automatic done_pulse();
    @(negedge clk);
    alu_done = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    alu_done = 1'b0;
  endtask

  task automatic go_show();
    press(4'hF); press(4'h1); press(4'hA); press(4'h2); press(4'hE);
    done_pulse();
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (disp_sel !== 2'b00) begin bad++; $display("FAIL reset_disp got=%b exp=00", disp_sel); end
    total++; if (digit_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", digit_count); end
    total++; if ({num1_en, num2_en, clr, res_to_op1, alu_start, op_sel, busy} !== 7'b0) begin
      bad++; $display("FAIL reset_pulses got=%b exp=0000000", {num1_en, num2_en, clr, res_to_op1, alu_start, op_sel, busy});
    end
    total++; if (digit !== 4'h0) begin bad++; $display("FAIL reset_digit got=%h exp=0", digit); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    clear_counts();
    press(4'h1);
    total++; if (s_num1 !== 1'b1 || s_digit !== 4'h1) begin bad++; $display("FAIL basic_d1 num1_en=%b digit=%h exp 1/1", s_num1, s_digit); end
    press(4'h2);
    total++; if (s_num1 !== 1'b1 || s_digit !== 4'h2 || s_count !== 3'd2) begin
      bad++; $display("FAIL basic_d2 num1_en=%b digit=%h cnt=%0d exp 1/2/2", s_num1, s_digit, s_count);
    end
    press(4'hA);
    total++; if (s_op !== 1'b0 || s_disp !== 2'b01 || s_count !== 3'd0) begin
      bad++; $display("FAIL basic_add op=%b disp=%b cnt=%0d exp 0/01/0", s_op, s_disp, s_count);
    end
    press(4'h3);
    total++; if (s_num2 !== 1'b1 || s_digit !== 4'h3) begin bad++; $display("FAIL basic_d3 num2_en=%b digit=%h exp 1/3", s_num2, s_digit); end
    press(4'hE);
    total++; if (s_start !== 1'b1) begin bad++; $display("FAIL basic_start got=%b exp=1", s_start); end
    repeat (4) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1 || disp_sel !== 2'b01) begin bad++; $display("FAIL basic_calc busy=%b disp=%b exp 1/01", busy, disp_sel); end
    @(negedge clk);
    alu_done = 1'b1;
    @(posedge clk); #1;
    total++; if (disp_sel !== 2'b10 || busy !== 1'b0) begin bad++; $display("FAIL basic_show disp=%b busy=%b exp 10/0", disp_sel, busy); end
    @(negedge clk);
    alu_done = 1'b0;
    total++; if (n_num1 !== 2 || n_num2 !== 1 || n_start !== 1) begin
      bad++; $display("FAIL basic_counts num1=%0d num2=%0d start=%0d exp 2/1/1", n_num1, n_num2, n_start);
    end
  endtask

  task automatic test_max_digits();
    press(4'hF);
    total++; if (s_clr !== 1'b1 || s_disp !== 2'b00) begin bad++; $display("FAIL clear_show clr=%b disp=%b exp 1/00", s_clr, s_disp); end
    clear_counts();
    for (int k = 1; k <= 5; k++) press(4'(k));
    total++; if (n_num1 !== 4) begin bad++; $display("FAIL max_pulses got=%0d exp=4", n_num1); end
    total++; if (digit_count !== 3'd4) begin bad++; $display("FAIL max_count got=%0d exp=4", digit_count); end
    total++; if (s_num1 !== 1'b0 || s_digit !== 4'h4) begin bad++; $display("FAIL max_fifth num1_en=%b digit=%h exp 0/4", s_num1, s_digit); end
  endtask

  task automatic test_held_key();
    press(4'hF);
    clear_counts();
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'h7;
    repeat (20) @(posedge clk);
    @(negedge clk);
    key_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (n_num1 !== 1 || digit !== 4'h7 || digit_count !== 3'd1) begin
      bad++; $display("FAIL held_key pulses=%0d digit=%h cnt=%0d exp 1/7/1", n_num1, digit, digit_count);
    end
  endtask

  task automatic test_show_chain();
    go_show();
    press(4'hB);
    total++; if (s_res !== 1'b1 || s_op !== 1'b1 || s_disp !== 2'b01 || s_count !== 3'd0) begin
      bad++; $display("FAIL show_op res=%b op=%b disp=%b cnt=%0d exp 1/1/01/0", s_res, s_op, s_disp, s_count);
    end
    press(4'h9);
    total++; if (s_num2 !== 1'b1 || s_digit !== 4'h9) begin bad++; $display("FAIL show_d9 num2_en=%b digit=%h exp 1/9", s_num2, s_digit); end
    press(4'hE);
    total++; if (s_start !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL show_eq start=%b busy=%b exp 1/1", s_start, busy); end
    done_pulse();
    press(4'h5);
    total++; if (s_clr !== 1'b1 || s_num1 !== 1'b0) begin bad++; $display("FAIL show_digit_e1 clr=%b num1_en=%b exp 1/0", s_clr, s_num1); end
    total++; if (s2_num1 !== 1'b1 || s2_clr !== 1'b0 || digit !== 4'h5 || digit_count !== 3'd1 || disp_sel !== 2'b00) begin
      bad++; $display("FAIL show_digit_e2 num1_en=%b clr=%b digit=%h cnt=%0d disp=%b exp 1/0/5/1/00", s2_num1, s2_clr, digit, digit_count, disp_sel);
    end
    go_show();
    press(4'hE);
    total++; if (s_start !== 1'b1 || s_disp !== 2'b01 || busy !== 1'b1) begin
      bad++; $display("FAIL show_reeq start=%b disp=%b busy=%b exp 1/01/1", s_start, s_disp, busy);
    end
  endtask

  task automatic test_clear_vs_done();
    press(4'hF); press(4'h4); press(4'hA); press(4'h5); press(4'hE);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'hF;
    alu_done  = 1'b1;
    @(posedge clk); #1;
    total++; if (clr !== 1'b1 || disp_sel !== 2'b00 || busy !== 1'b0) begin
      bad++; $display("FAIL clr_vs_done clr=%b disp=%b busy=%b exp 1/00/0", clr, disp_sel, busy);
    end
    @(negedge clk);
    key_valid = 1'b0;
    alu_done  = 1'b0;
    @(posedge clk); #1;
    total++; if (disp_sel !== 2'b00 || op_sel !== 1'b0) begin bad++; $display("FAIL clr_vs_done_after disp=%b op=%b exp 00/0", disp_sel, op_sel); end
  endtask

  task automatic test_ignored();
    press(4'hF);
    clear_counts();
    press(4'hE); press(4'hC); press(4'hD);
    done_pulse();
    @(posedge clk); #1;
    total++; if (disp_sel !== 2'b00 || digit_count !== 3'd0 || n_num1 !== 0 || n_start !== 0) begin
      bad++; $display("FAIL ign_n1 disp=%b cnt=%0d num1=%0d start=%0d exp 00/0/0/0", disp_sel, digit_count, n_num1, n_start);
    end
    press(4'hA);
    press(4'hE);
    total++; if (s_start !== 1'b0 || s_disp !== 2'b01) begin bad++; $display("FAIL ign_eq_empty start=%b disp=%b exp 0/01", s_start, s_disp); end
    press(4'hB);
    total++; if (s_op !== 1'b1 || s_disp !== 2'b01) begin bad++; $display("FAIL ign_relatch op=%b disp=%b exp 1/01", s_op, s_disp); end
    press(4'h6); press(4'hE);
    clear_counts();
    press(4'h8); press(4'hA);
    total++; if (busy !== 1'b1 || n_num1 !== 0 || n_num2 !== 0 || res_to_op1 !== 1'b0) begin
      bad++; $display("FAIL ign_calc busy=%b num1=%0d num2=%0d exp 1/0/0", busy, n_num1, n_num2);
    end
    done_pulse();
  endtask

  task automatic test_reset_mid();
    go_show();
    clear_counts();
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'h5;
    @(posedge clk); #1;
    @(negedge clk);
    reset     = 1'b1;
    key_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (num1_en !== 1'b0 || disp_sel !== 2'b00 || digit_count !== 3'd0) begin
      bad++; $display("FAIL reset_mid num1_en=%b disp=%b cnt=%0d exp 0/00/0", num1_en, disp_sel, digit_count);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if (n_num1 !== 0) begin bad++; $display("FAIL reset_mid_pend num1 pulses=%0d exp 0", n_num1); end
  endtask

  task automatic test_watchdog();
    press(4'hF); press(4'h1); press(4'hA); press(4'h2); press(4'hE);
`ifdef CALC_TIMEOUT_EN
    repeat (14) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1 || disp_sel !== 2'b01) begin bad++; $display("FAIL wdog_early busy=%b disp=%b exp 1/01", busy, disp_sel); end
    @(posedge clk); #1;
    total++; if (disp_sel !== 2'b11 || busy !== 1'b0) begin bad++; $display("FAIL wdog_err disp=%b busy=%b exp 11/0", disp_sel, busy); end
    clear_counts();
    press(4'h3);
    done_pulse();
    total++; if (n_num1 !== 0 || disp_sel !== 2'b11) begin bad++; $display("FAIL wdog_ign num1=%0d disp=%b exp 0/11", n_num1, disp_sel); end
    press(4'hF);
    total++; if (s_clr !== 1'b1 || s_disp !== 2'b00) begin bad++; $display("FAIL wdog_clear clr=%b disp=%b exp 1/00", s_clr, s_disp); end
`else
    repeat (40) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1 || disp_sel !== 2'b01) begin bad++; $display("FAIL no_wdog busy=%b disp=%b exp 1/01", busy, disp_sel); end
    press(4'hF);
    total++; if (s_disp !== 2'b00) begin bad++; $display("FAIL no_wdog_clear disp=%b exp 00", s_disp); end
`endif
  endtask

  initial begin
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    alu_done  = 1'b0;
    test_reset();
    test_basic();
    test_max_digits();
    test_held_key();
    test_show_chain();
    test_clear_vs_done();
    test_ignored();
    test_reset_mid();
    test_watchdog();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
